// File: rtl/hyperbus_pkg.sv
// Shared definitions for the hyperbus arbiter slice.
// Holds the one-hot FSM encoding, the timeout defaults, an index-width
// helper and the round-robin pick function used by rr_arbiter.
package hyperbus_pkg;

    localparam int MAX_NREQ         = 4;
    localparam int ACK_TIMEOUT_DEF  = 15;
    localparam int DONE_TIMEOUT_DEF = 255;

    typedef enum logic [4:0] {
        S_IDLE   = 5'b00001,
        S_ISSUE  = 5'b00010,
        S_ACTIVE = 5'b00100,
        S_DONE   = 5'b01000,
        S_ERROR  = 5'b10000
    } state_t;

    // Index width for n requesters, never less than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First set bit of req searching from ptr+1 modulo nreq. The loop runs
    // from the farthest candidate to the nearest so the nearest one wins.
    function automatic logic [1:0] rr_pick(input logic [MAX_NREQ-1:0] req,
                                           input logic [1:0] ptr,
                                           input int nreq);
        logic [1:0] pick;
        int         idx;
        pick = ptr;
        for (int k = nreq; k >= 1; k--) begin
            idx = (int'(ptr) + k) % nreq;
            if (req[idx]) pick = idx[1:0];
        end
        return pick;
    endfunction

endpackage

// File: rtl/hyperbus_arbiter_if.sv
// Requester-side and controller-side signals of the hyperbus arbiter.
// master: the arbiter (drives gnt/done/rdat/err and the hb_* requests).
// slave : the requesters plus controller (drive req_* and hb_* status).
interface hyperbus_arbiter_if #(
    parameter int NREQ  = 2,
    parameter int WIDTH = 8
);
    import hyperbus_pkg::*;
    localparam int IW = idx_w(NREQ);

    logic [NREQ-1:0]         req_rd;
    logic [NREQ-1:0]         req_wr;
    logic [NREQ-1:0]         req_reg;
    logic [NREQ*32-1:0]      req_adr;
    logic [NREQ*2*WIDTH-1:0] req_wdat;
    logic [NREQ-1:0]         gnt;
    logic [NREQ-1:0]         done;
    logic [2*WIDTH-1:0]      rdat;
    logic [NREQ-1:0]         rdat_valid;
    logic                    err;
    logic [IW-1:0]           err_owner;
    logic [31:0]             hb_adr;
    logic [2*WIDTH-1:0]      hb_dat;
    logic                    hb_reg_space;
    logic                    hb_rrq;
    logic                    hb_wrq;
    logic                    hb_busy;
    logic                    hb_dvalid;
    logic [2*WIDTH-1:0]      hb_dat_i;
    logic                    hb_error;

    modport master (
        input  req_rd, req_wr, req_reg, req_adr, req_wdat,
        input  hb_busy, hb_dvalid, hb_dat_i, hb_error,
        output gnt, done, rdat, rdat_valid, err, err_owner,
        output hb_adr, hb_dat, hb_reg_space, hb_rrq, hb_wrq
    );

    modport slave (
        output req_rd, req_wr, req_reg, req_adr, req_wdat,
        output hb_busy, hb_dvalid, hb_dat_i, hb_error,
        input  gnt, done, rdat, rdat_valid, err, err_owner,
        input  hb_adr, hb_dat, hb_reg_space, hb_rrq, hb_wrq
    );

endinterface

// File: rtl/hyperbus_arbiter_rr.sv
// Round-robin requester pick with a registered priority pointer.
// Ports: clk90/rst; req (request vector); upd/upd_idx load the pointer with
// the last served index; any = some request pending; pick = next winner;
// ptr = current pointer (reset NREQ-1 so index 0 is served first).
module rr_arbiter
    import hyperbus_pkg::*;
#(
    parameter  int NREQ = 2,
    localparam int IW   = idx_w(NREQ)
) (
    input  logic            clk90,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            upd,
    input  logic [IW-1:0]   upd_idx,
    output logic            any,
    output logic [IW-1:0]   pick,
    output logic [IW-1:0]   ptr
);

    always_ff @(posedge clk90) begin
        if (rst)      ptr <= IW'(NREQ - 1);
        else if (upd) ptr <= upd_idx;
    end

    assign any  = |req;
    assign pick = IW'(rr_pick(MAX_NREQ'(req), 2'(ptr), NREQ));

endmodule

// File: rtl/hyperbus_arbiter.sv
// Round-robin arbiter and transaction sequencer in front of one hyperbus
// controller. A granted request is latched and held on hb_* for the whole
// transaction; read data and completion are steered back to the owner and
// any controller error or timeout parks the block in a terminal error state.
// Ports: clk90, rst (sync, active-high); bus (master modport) carries the
// requester handshake and the controller request/status signals.
module hyperbus_arbiter
    import hyperbus_pkg::*;
#(
    parameter int NREQ         = 2,
    parameter int WIDTH        = 8,
    parameter int ACK_TIMEOUT  = ACK_TIMEOUT_DEF,
    parameter int DONE_TIMEOUT = DONE_TIMEOUT_DEF
) (
    input logic clk90,
    input logic rst,
    hyperbus_arbiter_if.master bus
);

    localparam int IW = idx_w(NREQ);
    localparam int W2 = 2 * WIDTH;

    state_t          state, state_n;
    logic [IW-1:0]   owner, pick, ptr;
    logic            any, dir_rd;
    logic [15:0]     cnt;
    logic [NREQ-1:0] pick_oh, own_oh;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .clk90   (clk90),
        .rst     (rst),
        .req     (bus.req_rd | bus.req_wr),
        .upd     (state == S_DONE),
        .upd_idx (owner),
        .any     (any),
        .pick    (pick),
        .ptr     (ptr)
    );

    assign pick_oh = NREQ'(1) << pick;
    assign own_oh  = NREQ'(1) << owner;

    always_ff @(posedge clk90) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   if (bus.hb_error)                  state_n = S_ERROR;
                      else if (any && !bus.hb_busy)      state_n = S_ISSUE;
            S_ISSUE:  if (bus.hb_error)                  state_n = S_ERROR;
                      else if (bus.hb_busy)              state_n = S_ACTIVE;
                      else if (cnt == 16'(ACK_TIMEOUT - 1))  state_n = S_ERROR;
            S_ACTIVE: if (bus.hb_error || cnt == 16'(DONE_TIMEOUT - 1))
                                                         state_n = S_ERROR;
                      else if (!bus.hb_busy)             state_n = S_DONE;
            S_DONE:   if (bus.hb_error)                  state_n = S_ERROR;
                      else                               state_n = S_IDLE;
            S_ERROR:                                     state_n = S_ERROR;
            default:                                     state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk90) begin
        if (rst) begin
            owner            <= '0;
            dir_rd           <= 1'b0;
            cnt              <= '0;
            bus.gnt          <= '0;
            bus.done         <= '0;
            bus.rdat         <= '0;
            bus.rdat_valid   <= '0;
            bus.err          <= 1'b0;
            bus.err_owner    <= '0;
            bus.hb_adr       <= '0;
            bus.hb_dat       <= '0;
            bus.hb_reg_space <= 1'b0;
            bus.hb_rrq       <= 1'b0;
            bus.hb_wrq       <= 1'b0;
        end else begin
            bus.gnt        <= '0;
            bus.done       <= '0;
            bus.rdat_valid <= '0;
            case (state)
                S_IDLE: if (state_n == S_ISSUE) begin
                    owner            <= pick;
                    dir_rd           <= bus.req_rd[pick];   // read wins over write
                    bus.gnt          <= pick_oh;
                    bus.hb_adr       <= bus.req_adr[32*int'(pick) +: 32];
                    bus.hb_dat       <= bus.req_wdat[W2*int'(pick) +: W2];
                    bus.hb_reg_space <= bus.req_reg[pick];
                    cnt              <= '0;
                end
                S_ISSUE: begin
                    // Request level starts one cycle after gnt and is held.
                    bus.hb_rrq <= dir_rd;
                    bus.hb_wrq <= ~dir_rd;
                    cnt        <= (state_n == S_ACTIVE) ? '0 : cnt + 16'd1;
                end
                S_ACTIVE: begin
                    cnt <= cnt + 16'd1;
                    if (bus.hb_dvalid) begin
                        bus.rdat       <= bus.hb_dat_i;
                        bus.rdat_valid <= own_oh;
                    end
                    if (state_n == S_DONE) begin
                        bus.hb_rrq <= 1'b0;
                        bus.hb_wrq <= 1'b0;
                        bus.done   <= own_oh;
                    end
                end
                default: ;
            endcase
            // Entering ERROR overrides anything set above this cycle.
            if (state != S_ERROR && state_n == S_ERROR) begin
                bus.hb_rrq    <= 1'b0;
                bus.hb_wrq    <= 1'b0;
                bus.err       <= 1'b1;
                bus.err_owner <= (state == S_IDLE) ? ptr : owner;
            end
        end
    end

endmodule

// File: tb/tb_hyperbus_arbiter.sv
module tb_hyperbus_arbiter;
    localparam int NREQ  = 2;
    localparam int WIDTH = 8;

    logic clk90 = 1'b0;
    logic rst   = 1'b1;
    always #5 clk90 = ~clk90;

    hyperbus_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    hyperbus_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .ACK_TIMEOUT(15), .DONE_TIMEOUT(255)) dut (
        .clk90 (clk90),
        .rst   (rst),
        .bus   (bus)
    );

    int pass_cnt = 0;
    int tot_cnt  = 0;

    logic [NREQ-1:0]    exp_gnt[$];
    logic [NREQ-1:0]    exp_done[$];
    logic [NREQ+15:0]   exp_rd[$];
    logic [0:0]         exp_err[$];
    logic               err_q = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk90);
        #1;
    endtask

    // Scoreboard monitor: pops an expectation whenever the DUT presents one.
    always @(negedge clk90) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            if (bus.gnt != 0) begin
                if (exp_gnt.size() == 0) chk("gnt_unexpected", bus.gnt, 0);
                else chk("gnt", bus.gnt, exp_gnt.pop_front());
            end
            if (bus.done != 0) begin
                if (exp_done.size() == 0) chk("done_unexpected", bus.done, 0);
                else chk("done", bus.done, exp_done.pop_front());
            end
            if (bus.rdat_valid != 0) begin
                if (exp_rd.size() == 0) chk("rdat_unexpected", bus.rdat_valid, 0);
                else chk("rdat", {bus.rdat_valid, bus.rdat}, exp_rd.pop_front());
            end
            if (bus.err && !err_q) begin
                if (exp_err.size() == 0) chk("err_unexpected", bus.err, 0);
                else chk("err_owner", bus.err_owner, exp_err.pop_front());
            end
            err_q <= bus.err;
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_hs"}, {bus.gnt, bus.done, bus.rdat_valid, bus.rdat}, 0);
        chk({tag, "_err"}, {bus.err, bus.err_owner}, 0);
        chk({tag, "_rq"}, {bus.hb_rrq, bus.hb_wrq}, 0);
        chk({tag, "_hb"}, {bus.hb_adr, bus.hb_dat, bus.hb_reg_space}, 0);
    endtask

    task automatic do_reset();
        bus.req_rd = '0; bus.req_wr = '0; bus.hb_busy = 0;
        bus.hb_dvalid = 0; bus.hb_error = 0;
        rst = 1'b1;
        cyc(2);
        chk_zero("reset");
        rst = 1'b0;
    endtask

    task automatic wait_gnt();
        int n = 0;
        while (bus.gnt == 0 && n < 20) begin cyc(1); n++; end
        chk("gnt_seen", bus.gnt != 0, 1);
    endtask

    // One transaction with a scripted controller: busy bdly cycles after the
    // request level, an optional dvalid beat, then busy drops.
    task automatic run_xact(input logic [1:0] g, input logic [1:0] drop, input int bdly,
                            input logic dv, input logic [15:0] d, input logic rd,
                            input logic [31:0] eadr, input logic [15:0] edat, input logic ereg);
        logic [63:0] sv_adr;
        logic [31:0] sv_wdat;
        logic [1:0]  sv_reg;
        int n = 0;
        exp_gnt.push_back(g);
        exp_done.push_back(g);
        if (dv) exp_rd.push_back({g, d});
        wait_gnt();
        bus.req_rd &= ~drop;
        bus.req_wr &= ~drop;
        // Scramble the request inputs: the latched values must not follow.
        sv_adr = bus.req_adr; sv_wdat = bus.req_wdat; sv_reg = bus.req_reg;
        bus.req_adr = ~sv_adr; bus.req_wdat = ~sv_wdat; bus.req_reg = ~sv_reg;
        while (!(bus.hb_rrq || bus.hb_wrq) && n < 20) begin cyc(1); n++; end
        chk("dir", {bus.hb_rrq, bus.hb_wrq}, {rd, ~rd});
        chk("hb_adr", bus.hb_adr, eadr);
        chk("hb_reg", bus.hb_reg_space, ereg);
        if (!rd) chk("hb_dat", bus.hb_dat, edat);
        bus.req_adr = sv_adr; bus.req_wdat = sv_wdat; bus.req_reg = sv_reg;
        cyc(bdly);
        bus.hb_busy = 1;
        cyc(1);
        if (dv) begin bus.hb_dvalid = 1; bus.hb_dat_i = d; end
        cyc(1);
        bus.hb_dvalid = 0;
        chk("req_held", {bus.hb_rrq, bus.hb_wrq}, {rd, ~rd});
        bus.hb_busy = 0;
        cyc(1);
        chk("req_dropped", {bus.hb_rrq, bus.hb_wrq}, 0);
        chk("hb_adr_stable", bus.hb_adr, eadr);
        cyc(1);
    endtask

    initial begin
        bus.req_rd = '0; bus.req_wr = '0; bus.req_reg = '0;
        bus.req_adr = {32'h0000_2000, 32'h0000_1000};
        bus.req_wdat = {16'h1234, 16'h5555};
        bus.hb_busy = 0; bus.hb_dvalid = 0; bus.hb_dat_i = '0; bus.hb_error = 0;
        do_reset();

        // dvalid while idle must not produce rdat_valid
        bus.hb_dvalid = 1; bus.hb_dat_i = 16'hDEAD;
        cyc(1);
        bus.hb_dvalid = 0;
        cyc(1);

        // single read from requester 0
        bus.req_rd = 2'b01;
        run_xact(2'b01, 2'b01, 2, 1, 16'hBEEF, 1, 32'h1000, 16'h0, 0);

        // simultaneous reads, grants 0,1,0 from reset
        do_reset();
        bus.req_rd = 2'b11;
        run_xact(2'b01, 2'b00, 2, 1, 16'h1111, 1, 32'h1000, 16'h0, 0);
        run_xact(2'b10, 2'b00, 1, 1, 16'h2222, 1, 32'h2000, 16'h0, 0);
        run_xact(2'b01, 2'b11, 3, 1, 16'h3333, 1, 32'h1000, 16'h0, 0);

        // rd+wr on requester 1: read wins; then register-space write
        bus.req_rd = 2'b10; bus.req_wr = 2'b10;
        run_xact(2'b10, 2'b10, 2, 1, 16'hA5A5, 1, 32'h2000, 16'h0, 0);
        bus.req_wr = 2'b10; bus.req_reg = 2'b10;
        run_xact(2'b10, 2'b10, 2, 0, 16'h0, 0, 32'h2000, 16'h1234, 1);
        bus.req_reg = 2'b00;

        // controller error mid-ACTIVE on requester 1
        exp_gnt.push_back(2'b10);
        exp_err.push_back(1'b1);
        bus.req_rd = 2'b10;
        wait_gnt();
        bus.req_rd = 2'b00;
        cyc(2);
        bus.hb_busy = 1;
        cyc(1);
        bus.hb_error = 1;
        cyc(1);
        chk("ctl_err", {bus.err, bus.err_owner}, 2'b11);
        chk("ctl_err_rq", {bus.hb_rrq, bus.hb_wrq}, 0);
        bus.hb_error = 0; bus.hb_busy = 0;
        bus.req_rd = 2'b01;
        cyc(6);
        chk("ctl_err_sticky", bus.err, 1);

        // ack timeout on requester 0, pending requests then ignored
        do_reset();
        exp_gnt.push_back(2'b01);
        exp_err.push_back(1'b0);
        bus.req_rd = 2'b01;
        wait_gnt();
        bus.req_rd = 2'b11;
        cyc(14);
        chk("ack_before", bus.err, 0);
        cyc(1);
        chk("ack_timeout", {bus.err, bus.err_owner}, 2'b10);
        chk("ack_rq", {bus.hb_rrq, bus.hb_wrq}, 0);
        cyc(10);

        // reset mid-ACTIVE, then requester 0 is served first
        do_reset();
        exp_gnt.push_back(2'b10);
        bus.req_rd = 2'b10;
        wait_gnt();
        bus.req_rd = 2'b00;
        cyc(2);
        bus.hb_busy = 1;
        cyc(2);
        chk("active_rrq", bus.hb_rrq, 1);
        rst = 1'b1;
        cyc(1);
        chk_zero("mid_reset");
        rst = 1'b0;
        bus.hb_busy = 0;
        bus.req_rd = 2'b11;
        run_xact(2'b01, 2'b11, 2, 1, 16'h7777, 1, 32'h1000, 16'h0, 0);

        cyc(3);
        chk("gnt_q_empty", exp_gnt.size(), 0);
        chk("done_q_empty", exp_done.size(), 0);
        chk("rd_q_empty", exp_rd.size() + exp_err.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
